countdown_ctrl: RTL and testbench

Run/pause/stop sequencer for the BCD seconds down-counter (00-59, borrow out) used in the timer datapath.
- Generates the seconds pulse from `clk` with a prescaler.
- Drives the counter's count-enable and load strobes.
- Owns the BCD minutes down-counter, which is decremented on the seconds borrow.
- Detects 00:00, stops the count and raises a timed alarm.

---
 rtl/countdown_pkg.sv | 40 ++++
 rtl/countdown_ctrl_prescaler.sv | 37 +++
 rtl/countdown_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared types and helpers for the countdown timer sequencer:
//   state_t      : FSM state encoding (IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4)
//   BCD_ZERO     : BCD 00
//   SEC_MAX      : BCD 59, the value the seconds counter wraps to
//   bcd_dec      : two-digit BCD decrement, holds at 00
//   preset_valid : minutes preset check (tens <= 5, units <= 9, not 00)
// -----------------------------------------------------------------------------
package countdown_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [7:0] SEC_MAX  = 8'h59;

  // x0 borrows from the tens digit and becomes (x-1)9; 00 holds.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v == BCD_ZERO) begin
      r = BCD_ZERO;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  function automatic logic preset_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9) && (v != BCD_ZERO);
  endfunction

endpackage

// File: rtl/countdown_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider that produces one tick per TICK_DIV enabled cycles.
//   clk  : system clock
//   rst  : synchronous active-high reset, count -> 0
//   clr  : synchronous clear, count -> 0 (wins over run)
//   run  : advance the count; when low the count is frozen
//   tick : high while running with the count at TICK_DIV-1 (the wrap cycle)
// -----------------------------------------------------------------------------
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int              CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = run && (cnt == CNT_MAX);

endmodule

// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
// Run/pause/stop sequencer for the BCD seconds down-counter. Generates the
// seconds pulse, drives the counter enable/load, owns the BCD minutes counter
// and raises a timed alarm when the count reaches 00:00.
//
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   key_start  : start / resume / alarm acknowledge
//   key_pause  : pause / resume toggle
//   key_clear  : abort to IDLE
//   min_preset : BCD minutes preset {tens, units}
//   sec_x      : BCD seconds from the seconds counter
//   sec_borrow : registered borrow from the seconds counter
//   pulse_out  : one-cycle seconds pulse to the counter
//   cnt_en     : counter enable
//   load       : one-cycle load strobe (counter returns to 00)
//   min_bcd    : BCD minutes remaining
//   alarm      : alarm active
//   state      : current FSM state
//
// Build option KEY_EDGE_EN: when defined, the three keys are level inputs and
// act once on their rising edge; otherwise each high cycle is a key event.
// -----------------------------------------------------------------------------
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int ALARM_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_pause,
  input  logic       key_clear,
  input  logic [7:0] min_preset,
  input  logic [7:0] sec_x,
  input  logic       sec_borrow,
  output logic       pulse_out,
  output logic       cnt_en,
  output logic       load,
  output logic [7:0] min_bcd,
  output logic       alarm,
  output logic [2:0] state
);

  localparam logic [3:0] WRAP_LAST = 4'(ALARM_SEC - 1);

  logic   ks, kp, kc;
  state_t st;
  logic   cnt_en_q;
  logic   [3:0] wrap_cnt;
  logic   tick;
  logic   run_zero;
  logic   presc_clr;
  logic   presc_run;

`ifdef KEY_EDGE_EN
  logic key_start_d, key_pause_d, key_clear_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_start_d <= 1'b0;
      key_pause_d <= 1'b0;
      key_clear_d <= 1'b0;
    end else begin
      key_start_d <= key_start;
      key_pause_d <= key_pause;
      key_clear_d <= key_clear;
    end
  end

  assign ks = key_start & ~key_start_d;
  assign kp = key_pause & ~key_pause_d;
  assign kc = key_clear & ~key_clear_d;
`else
  assign ks = key_start;
  assign kp = key_pause;
  assign kc = key_clear;
`endif

  // 00:00 reached while running: stop here so the counter never wraps to 59.
  assign run_zero = (st == ST_RUN) && (min_bcd == BCD_ZERO) && (sec_x == BCD_ZERO);

  // Clearing on DONE entry makes the alarm last exactly ALARM_SEC periods.
  assign presc_clr = kc || (st == ST_IDLE) || (st == ST_LOAD) || run_zero;
  assign presc_run = (st == ST_RUN) || (st == ST_DONE);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (presc_clr),
    .run (presc_run),
    .tick(tick)
  );

  assign pulse_out = tick && (st == ST_RUN) && !run_zero;
  assign cnt_en    = cnt_en_q && !run_zero;
  assign state     = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      cnt_en_q <= 1'b0;
      load     <= 1'b0;
      alarm    <= 1'b0;
      min_bcd  <= BCD_ZERO;
      wrap_cnt <= 4'd0;
    end else begin
      load <= 1'b0;
      if (kc) begin
        st       <= ST_IDLE;
        cnt_en_q <= 1'b0;
        alarm    <= 1'b0;
        min_bcd  <= BCD_ZERO;
        wrap_cnt <= 4'd0;
      end else begin
        case (st)
          ST_IDLE: begin
            if (ks && preset_valid(min_preset)) begin
              st      <= ST_LOAD;
              load    <= 1'b1;
              min_bcd <= min_preset;
            end
          end
          ST_LOAD: begin
            st       <= ST_RUN;
            cnt_en_q <= 1'b1;
          end
          ST_RUN: begin
            if (sec_borrow) begin
              min_bcd <= bcd_dec(min_bcd);
            end
            if (run_zero) begin
              st       <= ST_DONE;
              cnt_en_q <= 1'b0;
              alarm    <= 1'b1;
              wrap_cnt <= 4'd0;
            end else if (kp) begin
              st       <= ST_PAUSE;
              cnt_en_q <= 1'b0;
            end
          end
          ST_PAUSE: begin
            // The borrow from a pulse issued on the pausing cycle lands here.
            if (sec_borrow) begin
              min_bcd <= bcd_dec(min_bcd);
            end
            if (ks || kp) begin
              st       <= ST_RUN;
              cnt_en_q <= 1'b1;
            end
          end
          ST_DONE: begin
            if (ks) begin
              st    <= ST_IDLE;
              alarm <= 1'b0;
            end else if (tick) begin
              if (wrap_cnt == WRAP_LAST) begin
                st       <= ST_IDLE;
                alarm    <= 1'b0;
                wrap_cnt <= 4'd0;
              end else begin
                wrap_cnt <= wrap_cnt + 4'd1;
              end
            end
          end
          default: begin
            st       <= ST_IDLE;
            cnt_en_q <= 1'b0;
            alarm    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
// Bench for countdown_ctrl with TICK_DIV=4, ALARM_SEC=3. A model of the BCD
// seconds counter is attached to the DUT. Every cycle the DUT outputs are
// compared against a reference model that tracks mode, prescaler phase and
// minutes as plain integers. Directed scenarios are followed by random keys.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;
  import countdown_pkg::*;

  localparam int TD = 4;
  localparam int AS = 3;

  logic       clk;
  logic       rst;
  logic       key_start, key_pause, key_clear;
  logic [7:0] min_preset;
  logic [7:0] sec_x;
  logic       sec_borrow;
  logic       pulse_out, cnt_en, load, alarm;
  logic [7:0] min_bcd;
  logic [2:0] state;

  countdown_ctrl #(
    .TICK_DIV (TD),
    .ALARM_SEC(AS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key_pause (key_pause),
    .key_clear (key_clear),
    .min_preset(min_preset),
    .sec_x     (sec_x),
    .sec_borrow(sec_borrow),
    .pulse_out (pulse_out),
    .cnt_en    (cnt_en),
    .load      (load),
    .min_bcd   (min_bcd),
    .alarm     (alarm),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int bcd2bin(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Seconds counter attached to the DUT: load -> 00, pulse decrements,
  // 00 wraps to 59 with a registered borrow.
  always @(posedge clk) begin
    if (rst) begin
      sec_x      <= 8'h00;
      sec_borrow <= 1'b0;
    end else begin
      sec_borrow <= 1'b0;
      if (load) begin
        sec_x <= 8'h00;
      end else if (cnt_en && pulse_out) begin
        if (sec_x == 8'h00) begin
          sec_x      <= SEC_MAX;
          sec_borrow <= 1'b1;
        end else begin
          sec_x <= bin2bcd(bcd2bin(sec_x) - 1);
        end
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0..4 = IDLE, LOAD, RUN, PAUSE, DONE.
  int m_st = 0, m_presc = 0, m_min = 0, m_wrap = 0;
  logic p_ks = 1'b0, p_kp = 1'b0, p_kc = 1'b0;
  int n_pulse = 0, n_load = 0, n_alarm = 0, n_en = 0;
  logic obs_pulse;

  function automatic logic valid_preset(input logic [7:0] p);
    return (p[7:4] <= 4'd5) && (p[3:0] <= 4'd9) && (p != 8'h00);
  endfunction

  task automatic step();
    logic eks, ekp, ekc;
    logic zero;
    #1;
    zero = (m_st == 2) && (m_min == 0) && (bcd2bin(sec_x) == 0);
    obs_pulse = pulse_out;
    if (!rst) begin
      chk("state",     32'(state),     32'(m_st));
      chk("cnt_en",    32'(cnt_en),    32'(m_st == 2 && !zero));
      chk("load",      32'(load),      32'(m_st == 1));
      chk("alarm",     32'(alarm),     32'(m_st == 4));
      chk("min_bcd",   32'(min_bcd),   32'(bin2bcd(m_min)));
      chk("pulse_out", 32'(pulse_out), 32'(m_st == 2 && !zero && m_presc == TD - 1));
      if (pulse_out) n_pulse++;
      if (load)      n_load++;
      if (alarm)     n_alarm++;
      if (cnt_en)    n_en++;
    end
`ifdef KEY_EDGE_EN
    eks = key_start & ~p_ks;
    ekp = key_pause & ~p_kp;
    ekc = key_clear & ~p_kc;
`else
    eks = key_start;
    ekp = key_pause;
    ekc = key_clear;
`endif
    if (rst) begin
      m_st = 0; m_presc = 0; m_min = 0; m_wrap = 0;
      p_ks = 1'b0; p_kp = 1'b0; p_kc = 1'b0;
    end else begin
      p_ks = key_start; p_kp = key_pause; p_kc = key_clear;
      if (ekc) begin
        m_st = 0; m_min = 0; m_presc = 0; m_wrap = 0;
      end else begin
        case (m_st)
          0: begin
            m_presc = 0;
            if (eks && valid_preset(min_preset)) begin
              m_st  = 1;
              m_min = bcd2bin(min_preset);
            end
          end
          1: begin
            m_presc = 0;
            m_st    = 2;
          end
          2: begin
            if (zero) begin
              m_st = 4; m_presc = 0; m_wrap = 0;
            end else begin
              m_presc = (m_presc + 1) % TD;
              if (sec_borrow && m_min > 0) m_min--;
              if (ekp) m_st = 3;
            end
          end
          3: begin
            if (sec_borrow && m_min > 0) m_min--;
            if (eks || ekp) m_st = 2;
          end
          default: begin
            if (m_presc == TD - 1) m_wrap++;
            m_presc = (m_presc + 1) % TD;
            if (eks || m_wrap == AS) begin
              m_st = 0; m_wrap = 0;
            end
          end
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    key_start = 1'b1; step(); key_start = 1'b0;
  endtask

  task automatic press_pause();
    key_pause = 1'b1; step(); key_pause = 1'b0;
  endtask

  task automatic press_clear();
    key_clear = 1'b1; step(); key_clear = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bad [3];
    int d;
    int n_pe;
    logic [2:0] prev_st;
    bad = '{8'h00, 8'h60, 8'h1A};

    rst = 1'b1; key_start = 1'b0; key_pause = 1'b0; key_clear = 1'b0;
    min_preset = 8'h00;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'({pulse_out, cnt_en, load, alarm}), 32'd0);
    chk("rst_min", 32'(min_bcd), 32'h00);

    // 1-minute run to DONE, alarm, back to IDLE
    min_preset = 8'h01;
    n_load = 0; n_pulse = 0;
    press_start();
    for (int i = 0; i < 40 && !sec_borrow; i++) step();
    chk("wrap_sec", 32'(sec_x), 32'h59);
    step();
    chk("wrap_min", 32'(min_bcd), 32'h00);
    for (int i = 0; i < 400 && state != 3'd4; i++) step();
    chk("done_reached", 32'(state), 32'd4);
    chk("pulses_to_done", 32'(n_pulse), 32'd60);
    chk("sec_at_done", 32'(sec_x), 32'h00);
    chk("load_cycles", 32'(n_load), 32'd1);
    n_alarm = 0;
    for (int i = 0; i < 100 && state != 3'd0; i++) step();
    chk("alarm_cycles", 32'(n_alarm), 32'd12);
    chk("no_wrap_59", 32'(sec_x), 32'h00);

    // 10 -> 09 on first borrow
    min_preset = 8'h10;
    press_start();
    for (int i = 0; i < 40 && !sec_borrow; i++) step();
    step();
    chk("min_10_dec", 32'(min_bcd), 32'h09);
    press_clear();
    chk("clear_state", 32'(state), 32'd0);
    chk("clear_min", 32'(min_bcd), 32'h00);

    // pause with the prescaler frozen mid-period
    min_preset = 8'h05;
    press_start();
    for (int i = 0; i < 40 && !(m_st == 2 && m_presc == 1); i++) step();
    press_pause();
    n_pulse = 0; n_en = 0;
    repeat (20) step();
    chk("pause_state", 32'(state), 32'd3);
    chk("pause_pulses", 32'(n_pulse), 32'd0);
    chk("pause_cnt_en", 32'(n_en), 32'd0);
    press_start();
    d = 0;
    for (int i = 1; i <= 8 && d == 0; i++) begin
      step();
      if (obs_pulse) d = i;
    end
    chk("resume_latency", 32'(d), 32'd2);
    press_clear();

    // invalid presets are ignored
    for (int k = 0; k < 3; k++) begin
      min_preset = bad[k];
      n_load = 0;
      press_start();
      step(); step();
      chk("bad_preset_state", 32'(state), 32'd0);
      chk("bad_preset_load", 32'(n_load), 32'd0);
    end

    // clear and start together while running
    min_preset = 8'h02;
    press_start();
    repeat (10) step();
    key_start = 1'b1; key_clear = 1'b1;
    step();
    key_start = 1'b0; key_clear = 1'b0;
    chk("clr_start_state", 32'(state), 32'd0);
    chk("clr_start_min", 32'(min_bcd), 32'h00);

    // reset in the middle of a run
    min_preset = 8'h03;
    press_start();
    repeat (15) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_min", 32'(min_bcd), 32'h00);
    chk("rst_mid_en", 32'(cnt_en), 32'd0);

    // acknowledge the alarm
    min_preset = 8'h01;
    press_start();
    for (int i = 0; i < 400 && state != 3'd4; i++) step();
    step(); step();
    press_start();
    chk("ack_state", 32'(state), 32'd0);
    chk("ack_alarm", 32'(alarm), 32'd0);

    // held pause key
    min_preset = 8'h05;
    press_start();
    repeat (6) step();
    prev_st = state;
    n_pe = 0;
    for (int i = 0; i < 14; i++) begin
      key_pause = (i < 10);
      step();
      if (state == 3'd3 && prev_st != 3'd3) n_pe++;
      prev_st = state;
    end
    key_pause = 1'b0;
`ifdef KEY_EDGE_EN
    chk("held_pause_entries", 32'(n_pe), 32'd1);
`else
    chk("held_pause_entries", 32'(n_pe), 32'd5);
`endif
    press_clear();

    // random keys, presets and occasional reset
    for (int c = 0; c < 4000; c++) begin
      key_start = ($urandom_range(0, 19) == 0);
      key_pause = ($urandom_range(0, 29) == 0);
      key_clear = ($urandom_range(0, 399) == 0);
      rst       = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0:       min_preset = 8'h01;
          1:       min_preset = 8'h02;
          2:       min_preset = 8'h1A;
          default: min_preset = 8'($urandom_range(0, 255));
        endcase
      end
      step();
    end
    key_start = 1'b0; key_pause = 1'b0; key_clear = 1'b0; rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
